// File: rtl/vga_sprite_engine.sv
// vga_sprite_engine: single-sprite overlay for a VGA pixel stream.
// Three-clock pipeline from (hc, vc) to registered 3:3:2 RGB, with a synchronous-read sprite ROM
// and colour-key transparency. Position updates are handshaked and only take effect at the
// vertical-blank apply point, so a frame is never drawn with two positions.
// Optional build macro SPRITE_MIRROR_EN adds a 'mirror' input for horizontally flipped drawing.
module vga_sprite_engine #(
    parameter int unsigned SPR_W     = 32,
    parameter int unsigned SPR_H     = 32,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned V_VIS     = 480,
    parameter logic [7:0]  KEY_COLOR = 8'hE3
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              sel,
    input  logic              vidon,
    input  logic [9:0]        hc,
    input  logic [9:0]        vc,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              pos_valid,
    output logic              pos_ready,
`ifdef SPRITE_MIRROR_EN
    input  logic              mirror,
`endif
    input  logic [7:0]        rom_data,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [2:0]        red,
    output logic [2:0]        green,
    output logic [1:0]        blue,
    output logic              sprite_hit
);

    typedef enum logic {StIdle, StPend} state_e;

    state_e      state_q, state_d;
    logic [9:0]  act_x_q, act_x_d, act_y_q, act_y_d;
    logic [9:0]  pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic        apply;
    logic        act_mir;

`ifdef SPRITE_MIRROR_EN
    logic        act_mir_q, act_mir_d, pend_mir_q, pend_mir_d;
    assign act_mir = act_mir_q;
`else
    assign act_mir = 1'b0;
`endif

    // Single-cycle apply point: first pixel of the first non-visible line.
    assign apply = (vc == 10'(V_VIS)) && (hc == 10'd0);

    // Position handshake: next-state, pending/active register updates and pos_ready.
    always_comb begin
        state_d   = state_q;
        act_x_d   = act_x_q;
        act_y_d   = act_y_q;
        pend_x_d  = pend_x_q;
        pend_y_d  = pend_y_q;
`ifdef SPRITE_MIRROR_EN
        act_mir_d  = act_mir_q;
        pend_mir_d = pend_mir_q;
`endif
        pos_ready = (state_q == StIdle);
        case (state_q)
            StIdle: begin
                if (pos_valid) begin
                    if (apply) begin
                        // Request lands on the apply cycle itself: no need to wait a frame.
                        act_x_d = pos_x;
                        act_y_d = pos_y;
`ifdef SPRITE_MIRROR_EN
                        act_mir_d = mirror;
`endif
                    end else begin
                        pend_x_d = pos_x;
                        pend_y_d = pos_y;
`ifdef SPRITE_MIRROR_EN
                        pend_mir_d = mirror;
`endif
                        state_d  = StPend;
                    end
                end
            end
            StPend: begin
                if (apply) begin
                    act_x_d = pend_x_q;
                    act_y_d = pend_y_q;
`ifdef SPRITE_MIRROR_EN
                    act_mir_d = pend_mir_q;
`endif
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Position state register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= StIdle;
            act_x_q  <= '0;
            act_y_q  <= '0;
            pend_x_q <= '0;
            pend_y_q <= '0;
`ifdef SPRITE_MIRROR_EN
            act_mir_q  <= 1'b0;
            pend_mir_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            act_x_q  <= act_x_d;
            act_y_q  <= act_y_d;
            pend_x_q <= pend_x_d;
            pend_y_q <= pend_y_d;
`ifdef SPRITE_MIRROR_EN
            act_mir_q  <= act_mir_d;
            pend_mir_q <= pend_mir_d;
`endif
        end
    end

    // Stage 0 combinational: sprite window test (11-bit so edges near 1023 do not wrap) and address.
    logic [10:0]       x_end, y_end;
    logic              in_spr;
    logic [9:0]        row_off, col_off, col_term;
    logic [ADDR_W-1:0] addr_calc;

    always_comb begin
        x_end    = {1'b0, act_x_q} + 11'(SPR_W);
        y_end    = {1'b0, act_y_q} + 11'(SPR_H);
        in_spr   = ({1'b0, hc} >= {1'b0, act_x_q}) && ({1'b0, hc} < x_end) &&
                   ({1'b0, vc} >= {1'b0, act_y_q}) && ({1'b0, vc} < y_end);
        row_off  = vc - act_y_q;
        col_off  = hc - act_x_q;
        col_term = act_mir ? (10'(SPR_W - 1) - col_off) : col_off;
        addr_calc = ADDR_W'(row_off) * ADDR_W'(SPR_W) + ADDR_W'(col_term);
    end

    logic [ADDR_W-1:0] rom_addr_q;
    logic              in0_q, vid0_q, in1_q, vid1_q;

    assign rom_addr = rom_addr_q;

    // Pixel pipeline: address/flags, flag delay to meet ROM data, keyed colour output.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rom_addr_q <= '0;
            in0_q      <= 1'b0;
            vid0_q     <= 1'b0;
            in1_q      <= 1'b0;
            vid1_q     <= 1'b0;
            red        <= '0;
            green      <= '0;
            blue       <= '0;
            sprite_hit <= 1'b0;
        end else begin
            // Address only moves inside the sprite; outside it the last value is held.
            if (in_spr) begin
                rom_addr_q <= addr_calc;
            end
            in0_q  <= in_spr;
            vid0_q <= vidon & sel;
            in1_q  <= in0_q;
            vid1_q <= vid0_q;
            if (vid1_q && in1_q && (rom_data != KEY_COLOR)) begin
                {red, green, blue} <= rom_data;
                sprite_hit         <= 1'b1;
            end else begin
                {red, green, blue} <= 8'h00;
                sprite_hit         <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Self-checking bench for vga_sprite_engine: directed test-plan cases pinned with literal
// expectations, then randomized stimulus compared every cycle against a behavioural model.
module tb_vga_sprite_engine;

    localparam int SPR_W = 32;
    localparam int SPR_H = 32;
    localparam int V_VIS = 480;
    localparam int KEY   = 8'hE3;

    logic       clk = 1'b0;
    logic       clr, sel, vidon, pos_valid, pos_ready, mirror, sprite_hit;
    logic [9:0] hc, vc, pos_x, pos_y, rom_addr;
    logic [7:0] rom_data;
    logic [2:0] red, green;
    logic [1:0] blue;
    logic [7:0] rom [1024];

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state.
    int m_ax, m_ay, m_px, m_py, m_addr;
    bit m_pend, m_mir, m_pmir;
    bit qa_in, qa_vid, qb_in, qb_vid;
    int qa_addr, qb_addr;

    vga_sprite_engine dut (
        .clk        (clk),
        .clr        (clr),
        .sel        (sel),
        .vidon      (vidon),
        .hc         (hc),
        .vc         (vc),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .pos_valid  (pos_valid),
        .pos_ready  (pos_ready),
`ifdef SPRITE_MIRROR_EN
        .mirror     (mirror),
`endif
        .rom_data   (rom_data),
        .rom_addr   (rom_addr),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .sprite_hit (sprite_hit)
    );

    always #5 clk = ~clk;

    // Synchronous-read sprite ROM.
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ax = 0; m_ay = 0; m_px = 0; m_py = 0; m_addr = 0;
        m_pend = 0; m_mir = 0; m_pmir = 0;
        qa_in = 0; qa_vid = 0; qa_addr = 0;
        qb_in = 0; qb_vid = 0; qb_addr = 0;
    endtask

    // One pixel clock: drive inputs, advance model, compare at the next falling edge.
    task automatic step(input int h, input int v, input bit vd, input bit s,
                        input bit pv, input int px, input int py, input bit mir);
        bit in_now, apply, e_hit;
        int e_pix, col;
        hc = 10'(h); vc = 10'(v); vidon = vd; sel = s;
        pos_valid = pv; pos_x = 10'(px); pos_y = 10'(py); mirror = mir;
        in_now = (h >= m_ax) && (h < m_ax + SPR_W) && (v >= m_ay) && (v < m_ay + SPR_H);
        if (in_now) begin
            col    = m_mir ? (SPR_W - 1 - (h - m_ax)) : (h - m_ax);
            m_addr = (v - m_ay) * SPR_W + col;
        end
        // Output after this edge comes from the pixel presented two edges earlier.
        if (qb_in && qb_vid && int'(rom[qb_addr]) != KEY) begin
            e_pix = int'(rom[qb_addr]); e_hit = 1'b1;
        end else begin
            e_pix = 0; e_hit = 1'b0;
        end
        qb_in = qa_in; qb_vid = qa_vid; qb_addr = qa_addr;
        qa_in = in_now; qa_vid = vd && s; qa_addr = m_addr;
        apply = (v == V_VIS) && (h == 0);
        if (!m_pend) begin
            if (pv) begin
                if (apply) begin
                    m_ax = px; m_ay = py;
`ifdef SPRITE_MIRROR_EN
                    m_mir = mir;
`endif
                end else begin
                    m_px = px; m_py = py; m_pend = 1'b1;
`ifdef SPRITE_MIRROR_EN
                    m_pmir = mir;
`endif
                end
            end
        end else if (apply) begin
            m_ax = m_px; m_ay = m_py; m_mir = m_pmir; m_pend = 1'b0;
        end
        @(negedge clk);
        check("rom_addr", int'(rom_addr), m_addr);
        check("pos_ready", int'(pos_ready), int'(!m_pend));
        check("rgb", int'({red, green, blue}), e_pix);
        check("sprite_hit", int'(sprite_hit), int'(e_hit));
    endtask

    // Short helper for ordinary visible pixels without a request.
    task automatic px_step(input int h, input int v);
        step(h, v, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear without a clock.
    task automatic mid_reset();
        #2 clr = 1'b0;
        #1;
        check("async_rom_addr", int'(rom_addr), 0);
        check("async_rgb", int'({red, green, blue}), 0);
        check("async_hit", int'(sprite_hit), 0);
        check("async_ready", int'(pos_ready), 1);
        @(negedge clk);
        clr = 1'b1;
        model_reset();
    endtask

    initial begin
        int h, v, px, py;
        for (int i = 0; i < 1024; i++) begin
            rom[i] = ($urandom_range(0, 7) == 0) ? 8'hE3 : 8'($urandom_range(0, 255));
        end
        rom[0] = 8'hFF;
        rom[2] = 8'hE3;
        rom[3] = 8'h1C;

        clr = 1'b0; sel = 1'b0; vidon = 1'b0; pos_valid = 1'b0; mirror = 1'b0;
        hc = '0; vc = '0; pos_x = '0; pos_y = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_ready", int'(pos_ready), 1);
        check("reset_addr", int'(rom_addr), 0);
        check("reset_rgb", int'({red, green, blue}), 0);
        check("reset_hit", int'(sprite_hit), 0);
        clr = 1'b1;

        // First pixel of sprite at (0,0): address at t+1, colour at t+3.
        px_step(0, 0);
        check("lit_addr0", int'(rom_addr), 0);
        px_step(500, 0);
        px_step(500, 0);
        check("lit_red7", int'(red), 7);
        check("lit_green7", int'(green), 7);
        check("lit_blue3", int'(blue), 3);
        check("lit_hit1", int'(sprite_hit), 1);

        // Mid-frame request: pending until vertical blank; second request ignored.
        step(10, 200, 1'b1, 1'b1, 1'b1, 100, 50, 1'b0);
        check("lit_ready_drop", int'(pos_ready), 0);
        px_step(5, 5);
        check("lit_old_pos", int'(rom_addr), 165);
        step(400, 300, 1'b1, 1'b1, 1'b1, 7, 7, 1'b0);
        check("lit_still_pend", int'(pos_ready), 0);
        step(0, 480, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        check("lit_ready_back", int'(pos_ready), 1);
        px_step(100, 50);
        check("lit_new_first", int'(rom_addr), 0);
        px_step(131, 81);
        check("lit_new_last", int'(rom_addr), 1023);

        // Key colour transparent; neighbour 8'h1C is pure green.
        px_step(102, 50);
        px_step(103, 50);
        px_step(600, 0);
        check("lit_key_rgb", int'({red, green, blue}), 0);
        check("lit_key_hit", int'(sprite_hit), 0);
        px_step(600, 0);
        check("lit_g_red", int'(red), 0);
        check("lit_g_green", int'(green), 7);
        check("lit_g_blue", int'(blue), 0);
        check("lit_g_hit", int'(sprite_hit), 1);

        // Sprite hanging past the right edge.
        step(1, 1, 1'b1, 1'b1, 1'b1, 620, 470, 1'b0);
        step(0, 480, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        px_step(639, 479);
        check("lit_edge_addr", int'(rom_addr), 307);
        step(640, 479, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        px_step(700, 0);
        px_step(700, 0);
        check("lit_clip_rgb", int'({red, green, blue}), 0);
        check("lit_clip_hit", int'(sprite_hit), 0);

        // Capture exactly on the apply cycle.
        step(0, 480, 1'b0, 1'b1, 1'b1, 200, 100, 1'b0);
        check("lit_apply_ready", int'(pos_ready), 1);
        px_step(200, 100);
        check("lit_apply_addr", int'(rom_addr), 0);

        // Reset with a request pending: position falls back to (0,0).
        step(5, 5, 1'b1, 1'b1, 1'b1, 10, 10, 1'b0);
        mid_reset();
        px_step(5, 0);
        check("lit_rst_pos", int'(rom_addr), 5);

`ifdef SPRITE_MIRROR_EN
        step(1, 1, 1'b1, 1'b1, 1'b1, 300, 200, 1'b1);
        step(0, 480, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        px_step(300, 205);
        check("lit_mirror", int'(rom_addr), 5 * 32 + 31);
`endif

        // Randomized phase.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                h = 0; v = V_VIS;
            end else if ($urandom_range(0, 1) == 0) begin
                h = m_ax + int'($urandom_range(0, 40)) - 4;
                v = m_ay + int'($urandom_range(0, 40)) - 4;
            end else begin
                h = int'($urandom_range(0, 1023));
                v = int'($urandom_range(0, 1023));
            end
            if (h < 0) h = 0;
            if (h > 1023) h = 1023;
            if (v < 0) v = 0;
            if (v > 1023) v = 1023;
            if ($urandom_range(0, 3) == 0) begin
                px = int'($urandom_range(990, 1023)); py = int'($urandom_range(990, 1023));
            end else begin
                px = int'($urandom_range(0, 639)); py = int'($urandom_range(0, 479));
            end
            step(h, v, $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0,
                 $urandom_range(0, 7) == 0, px, py, 1'($urandom_range(0, 1)));
            if (n == 2000) mid_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_sprite_engine.md
Name: vga_sprite_engine

Overview:
- Parametrised successor to the single-sprite pixel mux.
- Draws one SPR_W x SPR_H sprite at a runtime-movable (x,y) position over a black background.
- Drives a synchronous-read sprite ROM and returns registered 8-bit RGB (3:3:2) with colour-key transparency.
- Sits between the VGA timing generator (hc, vc, vidon) and the DAC pins; position updates come from game/control logic through a valid/ready handshake and take effect only at vertical blank, so no frame tears.

Parameters:
- SPR_W, 32, sprite width in pixels (power of 2 not required)
- SPR_H, 32, sprite height in lines
- ADDR_W, 10, ROM address width; must satisfy 2^ADDR_W >= SPR_W*SPR_H
- V_VIS, 480, first non-visible line; position apply point
- KEY_COLOR, 8'hE3, ROM value treated as transparent

Ports:
- clk  in  1  pixel clock
- clr  in  1  asynchronous active-low reset
- sel  in  1  engine enable; 0 forces black output
- vidon  in  1  visible-area flag from timing generator
- hc  in  10  horizontal pixel count
- vc  in  10  vertical line count
- pos_x  in  10  requested sprite left column
- pos_y  in  10  requested sprite top line
- pos_valid  in  1  position request valid
- pos_ready  out  1  engine can accept a position request
- rom_data  in  8  ROM word, valid 1 clk after rom_addr
- rom_addr  out  ADDR_W  registered sprite ROM address
- red  out  3  pixel red
- green  out  3  pixel green
- blue  out  2  pixel blue
- sprite_hit  out  1  current output pixel is an opaque sprite pixel

Behaviour:
- Reset (clr=0, async): active position (0,0), pending register cleared, pos_ready=1, rom_addr=0, red/green/blue=0, sprite_hit=0, pipeline flags cleared.
- Position FSM states:
  - IDLE (pos_ready=1): pos_valid=1 captures pos_x/pos_y into pending and goes to PEND.
  - PEND (pos_ready=0): at the apply event, pending copies to active, then IDLE.
  - Apply event = single cycle with vc==V_VIS && hc==0.
  - Capture in IDLE on the apply cycle writes active directly and stays IDLE.
  - pos_valid in PEND is ignored.
- Stage 0 (edge t+1):
  - in = (hc >= ax) && (hc < ax+SPR_W) && (vc >= ay) && (vc < ay+SPR_H).
  - Sums are computed 11 bits wide, so positions near 1023 do not wrap.
  - rom_addr <= (vc-ay)*SPR_W + (hc-ax) when in, else held.
  - in and vidon&sel are registered alongside.
- Stage 1 (edge t+2): in/vid flags delayed one more stage to align with rom_data.
- Stage 2 (edge t+3): if vid && in && rom_data!=KEY_COLOR, then {red,green,blue}<=rom_data and sprite_hit<=1; else 0 and 0.
- Latency is exactly 3 clk from hc/vc to RGB; the parent delays hsync/vsync by 3.
- Clipping:
  - The sprite may extend past visible edges; pixels outside vidon output black.
  - No address is generated for rows/cols outside the sprite.
- sel=0 forces black and sprite_hit=0 after the same 3-clk latency; no latched outputs.
- Reset mid-frame: the active position returns to (0,0) immediately; drawing resumes the next cycle.

Optional Feature:
- SPRITE_MIRROR_EN:
  - Defined: adds input port mirror (1 bit), sampled with the position on apply. When the applied mirror=1, the column term becomes (SPR_W-1-(hc-ax)), giving a horizontally flipped sprite. Latency unchanged.
  - Undefined: no mirror port; column term is always (hc-ax).

Test Plan:
- Reset then sel=1, vidon=1, active (0,0), ROM addr 0 = 8'hFF, hc=0/vc=0 -> rom_addr=0 at t+1; RGB=7,7,3 and sprite_hit=1 at t+3.
- pos_valid with (100,50) mid-frame at vc=200 -> pos_ready drops; sprite still drawn at (0,0) until vc=480,hc=0; from then hc=100,vc=50 gives rom_addr=0 and hc=131,vc=81 gives rom_addr=1023.
- ROM word = KEY_COLOR at an in-sprite pixel -> RGB=0, sprite_hit=0; neighbour word 8'h1C -> green=7 only.
- Position (620,470), hc=639/vc=479 -> rom_addr=9*32+19=307; at hc=640 vidon=0 -> black.
- Capture on the exact apply cycle -> new position live next frame, pos_ready stays 1; second pos_valid while PEND -> ignored.
- clr asserted mid-line -> outputs 0 asynchronously, position (0,0); with SPRITE_MIRROR_EN and mirror=1, hc=ax -> rom_addr=(vc-ay)*32+31.
